// File: rtl/vec_ctrl_pkg.sv
// Shared control definitions for the vector pixel sequencer and the CPU top.
// Holds the sequencer state encoding and the default lane and drain sizing.
package vec_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } vec_state_e;

  localparam int LANES_DEF        = 4;
  localparam int DRAIN_CYCLES_DEF = 4;

endpackage

// File: rtl/pix_addr_gen.sv
// Pixel position counters: row i, column j, linear index n and WOM address.
// Advances by LANES pixels per step and wraps to the next row at the row end.
module pix_addr_gen
  import vec_ctrl_pkg::*;
#(
  parameter int LANES = LANES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic        advance_i,
  input  logic [31:0] base_i,
  input  logic [31:0] img_w_i,
  input  logic [31:0] img_h_i,
  output logic [31:0] i_o,
  output logic [31:0] j_o,
  output logic [31:0] n_o,
  output logic [31:0] addr_o,
  output logic        last_o
);

  localparam logic [31:0] STEP = 32'(LANES);

  logic [31:0] i_q, i_d;
  logic [31:0] j_q, j_d;
  logic [31:0] n_q, n_d;
  logic [31:0] addr_q, addr_d;
  logic        row_end;

  assign row_end = (j_q + STEP) == img_w_i;

  always_comb begin
    i_d    = i_q;
    j_d    = j_q;
    n_d    = n_q;
    addr_d = addr_q;
    if (load_i) begin
      i_d    = '0;
      j_d    = '0;
      n_d    = '0;
      addr_d = base_i;
    end else if (advance_i) begin
      // n and the address wrap modulo 2^32 by plain unsigned overflow
      n_d    = n_q + STEP;
      addr_d = addr_q + STEP;
      if (row_end) begin
        j_d = '0;
        i_d = i_q + 32'd1;
      end else begin
        j_d = j_q + STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_q    <= '0;
      j_q    <= '0;
      n_q    <= '0;
      addr_q <= '0;
    end else begin
      i_q    <= i_d;
      j_q    <= j_d;
      n_q    <= n_d;
      addr_q <= addr_d;
    end
  end

  assign i_o    = i_q;
  assign j_o    = j_q;
  assign n_o    = n_q;
  assign addr_o = addr_q;
  assign last_o = (i_q == img_h_i - 32'd1) && (j_q == img_w_i - STEP);

endmodule

// File: rtl/vec_pixel_sequencer.sv
// Frame sequencer: issues LANES pixels per cycle to the execution datapath,
// then waits for the pipeline to drain before pulsing done.
module vec_pixel_sequencer
  import vec_ctrl_pkg::*;
#(
  parameter int LANES        = LANES_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        abort,
  input  logic        stall,
  input  logic [31:0] img_w,
  input  logic [31:0] img_h,
  input  logic [31:0] wom_base,
  output logic        issue_valid,
  output logic        wr_wom,
  output logic [31:0] i,
  output logic [31:0] j,
  output logic [31:0] n,
  output logic [31:0] wom_addr,
  output logic        last,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [31:0] STEP       = 32'(LANES);
  localparam logic [31:0] DRAIN_LAST = 32'(DRAIN_CYCLES - 1);

  vec_state_e  state_q, state_d;
  logic [31:0] drain_q, drain_d;
  logic [31:0] img_w_q, img_h_q;
  logic        err_q, err_d;
  logic        cfg_bad, cfg_empty, at_last, load, advance, accept;

  assign accept    = (state_q == ST_IDLE) && start;
  assign cfg_bad   = (img_w % STEP) != 32'd0;
  assign cfg_empty = (img_w == 32'd0) || (img_h == 32'd0);

  pix_addr_gen #(.LANES(LANES)) u_addr (
    .clk       (clk),
    .rst       (rst),
    .load_i    (load),
    .advance_i (advance),
    .base_i    (wom_base),
    .img_w_i   (img_w_q),
    .img_h_i   (img_h_q),
    .i_o       (i),
    .j_o       (j),
    .n_o       (n),
    .addr_o    (wom_addr),
    .last_o    (at_last)
  );

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    err_d   = err_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = cfg_bad;
          if (!cfg_bad) begin
            if (cfg_empty) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_RUN;
              load    = 1'b1;
            end
          end
        end
      end
      ST_RUN: begin
        // abort outranks both stall and a final issue; the final issue holds position
        if (abort) begin
          state_d = ST_IDLE;
        end else if (!stall) begin
          if (at_last) begin
            state_d = ST_DRAIN;
            drain_d = '0;
          end else begin
            advance = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (drain_q == DRAIN_LAST) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q + 32'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      err_q   <= 1'b0;
      img_w_q <= '0;
      img_h_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      if (accept) begin
        img_w_q <= img_w;
        img_h_q <= img_h;
      end
    end
  end

  assign issue_valid = (state_q == ST_RUN);
  assign wr_wom      = issue_valid;
  assign last        = issue_valid && at_last;
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign err         = err_q;

endmodule

// File: tb/tb_vec_pixel_sequencer.sv
// Bench for vec_pixel_sequencer: directed frames plus randomized frames checked
// against an expected issue list built from nested row/column loops.
module tb_vec_pixel_sequencer;
  import vec_ctrl_pkg::*;

  localparam int LANES = LANES_DEF;
  localparam int DRAIN = DRAIN_CYCLES_DEF;

  logic        clk = 1'b0;
  logic        rst, start, abort, stall;
  logic [31:0] img_w, img_h, wom_base;
  logic        issue_valid, wr_wom, last, busy, done, err;
  logic [31:0] i, j, n, wom_addr;

  int n_cmp = 0;
  int n_mis = 0;

  logic [31:0] e_i[$];
  logic [31:0] e_j[$];
  logic [31:0] e_n[$];
  logic [31:0] e_a[$];

  always #5 clk = ~clk;

  vec_pixel_sequencer #(.LANES(LANES), .DRAIN_CYCLES(DRAIN)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .abort       (abort),
    .stall       (stall),
    .img_w       (img_w),
    .img_h       (img_h),
    .wom_base    (wom_base),
    .issue_valid (issue_valid),
    .wr_wom      (wr_wom),
    .i           (i),
    .j           (j),
    .n           (n),
    .wom_addr    (wom_addr),
    .last        (last),
    .busy        (busy),
    .done        (done),
    .err         (err)
  );

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk_eq({tag, "_valid"}, 32'(issue_valid), 32'd0);
    chk_eq({tag, "_wr"},    32'(wr_wom),      32'd0);
    chk_eq({tag, "_i"},     i,                32'd0);
    chk_eq({tag, "_j"},     j,                32'd0);
    chk_eq({tag, "_n"},     n,                32'd0);
    chk_eq({tag, "_addr"},  wom_addr,         32'd0);
    chk_eq({tag, "_last"},  32'(last),        32'd0);
    chk_eq({tag, "_busy"},  32'(busy),        32'd0);
    chk_eq({tag, "_done"},  32'(done),        32'd0);
    chk_eq({tag, "_err"},   32'(err),         32'd0);
  endtask

  // One frame: start it, then follow the expected issue list cycle by cycle.
  task automatic run_frame(input logic [31:0] w, input logic [31:0] h, input logic [31:0] base,
                           input int stall_pct, input int hold_k, input int hold_n,
                           input int abort_k, input bit rst_drain, input bit noise);
    bit   bad, empty, exp_valid, exp_done;
    int   k, post, held, issued, sz;
    e_i.delete(); e_j.delete(); e_n.delete(); e_a.delete();
    bad   = (w % 32'(LANES)) != 32'd0;
    empty = !bad && (w == 32'd0 || h == 32'd0);
    if (!bad) begin
      for (longint r = 0; r < longint'(h); r++) begin
        for (longint c = 0; c < longint'(w); c += LANES) begin
          e_i.push_back(32'(r));
          e_j.push_back(32'(c));
          e_n.push_back(32'(r * longint'(w) + c));
          e_a.push_back(base + 32'(r * longint'(w) + c));
        end
      end
    end
    sz = e_i.size();

    start = 1'b1; abort = 1'b0; stall = 1'b0;
    img_w = w; img_h = h; wom_base = base;
    @(posedge clk); #1;
    start = 1'b0;
    if (bad) begin
      @(negedge clk);
      chk_eq("err_set",   32'(err),         32'd1);
      chk_eq("err_busy",  32'(busy),        32'd0);
      chk_eq("err_valid", 32'(issue_valid), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      chk_eq("err_sticky",  32'(err),         32'd1);
      chk_eq("err_noissue", 32'(issue_valid), 32'd0);
      return;
    end
    chk_eq("err_clr", 32'(err), 32'd0);

    k = 0; post = -1; held = 0; issued = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      stall = 1'b0;
      if (k == hold_k && held < hold_n) begin
        stall = 1'b1;
        held++;
      end else if (int'($urandom_range(99)) < stall_pct) begin
        stall = 1'b1;
      end
      exp_valid = !empty && post < 0 && k < sz;
      abort = exp_valid && (k == abort_k);
      if (noise) begin
        start    = ($urandom_range(3) == 0);
        img_w    = $urandom;
        img_h    = $urandom;
        wom_base = $urandom;
      end
      if (post >= 0) post++;
      exp_done = empty ? (cyc == 0) : (post == DRAIN + 1);

      @(negedge clk);
      chk_eq("busy",  32'(busy),        32'd1);
      chk_eq("valid", 32'(issue_valid), 32'(exp_valid));
      chk_eq("wr",    32'(wr_wom),      32'(exp_valid));
      chk_eq("done",  32'(done),        32'(exp_done));
      chk_eq("err",   32'(err),         32'd0);
      if (exp_valid) begin
        chk_eq("i",    i,         e_i[k]);
        chk_eq("j",    j,         e_j[k]);
        chk_eq("n",    n,         e_n[k]);
        chk_eq("addr", wom_addr,  e_a[k]);
        chk_eq("last", 32'(last), 32'(k == sz - 1));
        if (abort) begin
          @(posedge clk); #1;
          abort = 1'b0; start = 1'b0; stall = 1'b0;
          @(negedge clk);
          chk_eq("ab_busy",  32'(busy),        32'd0);
          chk_eq("ab_valid", 32'(issue_valid), 32'd0);
          chk_eq("ab_i",     i,                e_i[k]);
          chk_eq("ab_j",     j,                e_j[k]);
          chk_eq("ab_addr",  wom_addr,         e_a[k]);
          for (int q = 0; q < DRAIN + 2; q++) begin
            @(negedge clk);
            chk_eq("ab_nodone", 32'(done), 32'd0);
          end
          return;
        end
        if (!stall) begin
          issued++;
          if (k == sz - 1) post = 0;
          k++;
        end
      end else if (post >= 0 && sz > 0) begin
        chk_eq("hold_i",    i,         e_i[sz-1]);
        chk_eq("hold_n",    n,         e_n[sz-1]);
        chk_eq("hold_addr", wom_addr,  e_a[sz-1]);
        chk_eq("hold_last", 32'(last), 32'd0);
        if (rst_drain && post == 2) begin
          rst = 1'b1;
          #1;
          chk_all_zero("rst_drain");
          start = 1'b0; stall = 1'b0;
          @(posedge clk); #2;
          rst = 1'b0;
          for (int q = 0; q < DRAIN + 3; q++) begin
            @(negedge clk);
            chk_eq("rst_nodone", 32'(done), 32'd0);
            chk_eq("rst_idle",   32'(busy), 32'd0);
          end
          return;
        end
      end
      if (exp_done) begin
        @(posedge clk); #1;
        start = 1'b0; stall = 1'b0;
        chk_eq("idle_busy", 32'(busy),   32'd0);
        chk_eq("idle_done", 32'(done),   32'd0);
        chk_eq("issued",    32'(issued), 32'(sz));
        return;
      end
      @(posedge clk); #1;
    end
    chk_eq("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    logic [31:0] w, h;
    int ak;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stall = 1'b0;
    img_w = '0; img_h = '0; wom_base = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;

    run_frame(32'd8, 32'd2, 32'h100, 0, -1, 0, -1, 1'b0, 1'b0);
    run_frame(32'd8, 32'd2, 32'h100, 0,  1, 3, -1, 1'b0, 1'b0);
    run_frame(32'd6, 32'd2, 32'h0,   0, -1, 0, -1, 1'b0, 1'b0);
    run_frame(32'd8, 32'd0, 32'h40,  0, -1, 0, -1, 1'b0, 1'b0);
    run_frame(32'd0, 32'd3, 32'h40,  0, -1, 0, -1, 1'b0, 1'b0);
    run_frame(32'd8, 32'd2, 32'h100, 0, -1, 0,  2, 1'b0, 1'b0);
    run_frame(32'd8, 32'd2, 32'h100, 0, -1, 0, -1, 1'b0, 1'b0);
    run_frame(32'd8, 32'd1, 32'hFFFF_FFFC, 0, -1, 0, -1, 1'b1, 1'b0);
    run_frame(32'd4, 32'd1, 32'h200, 0, -1, 0, -1, 1'b0, 1'b0);

    for (int f = 0; f < 40; f++) begin
      w = 32'(LANES) * $urandom_range(0, 6);
      if ($urandom_range(9) == 0) w = w + $urandom_range(1, 3);
      h = $urandom_range(0, 4);
      ak = ($urandom_range(4) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_frame(w, h, $urandom, 30, -1, 0, ak, 1'b0, 1'b1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
